// File: rtl/alu_status_pkg.sv
// Shared types and constants for the adder result/status stage and its condition evaluator.
package alu_status_pkg;

  localparam int FLG_C = 0;
  localparam int FLG_S = 1;
  localparam int FLG_Z = 2;
  localparam int FLG_P = 3;
  localparam int FLG_V = 4;

  typedef enum logic [3:0] {
    CC_ALWAYS = 4'd0,
    CC_Z      = 4'd1,
    CC_NZ     = 4'd2,
    CC_C      = 4'd3,
    CC_NC     = 4'd4,
    CC_S      = 4'd5,
    CC_NS     = 4'd6,
    CC_V      = 4'd7,
    CC_NV     = 4'd8,
    CC_P      = 4'd9,
    CC_NP     = 4'd10,
    CC_LT     = 4'd11,
    CC_GE     = 4'd12
  } cond_e;

  typedef struct packed {
    logic [15:0] sum;
    logic [4:0]  flags;
  } entry_t;

endpackage

// File: rtl/alu_status_stage_cond_eval.sv
// Combinational condition-code evaluator over packed {v,p,z,s,c} flags.
module cond_eval
  import alu_status_pkg::*;
(
  input  logic [3:0] cond_sel,
  input  logic [4:0] flags,
  output logic       cond_true
);

  logic s_xor_v;
  assign s_xor_v = flags[FLG_S] ^ flags[FLG_V];

  always_comb begin
    cond_true = 1'b0;
    case (cond_e'(cond_sel))
      CC_ALWAYS: cond_true = 1'b1;
      CC_Z:      cond_true = flags[FLG_Z];
      CC_NZ:     cond_true = ~flags[FLG_Z];
      CC_C:      cond_true = flags[FLG_C];
      CC_NC:     cond_true = ~flags[FLG_C];
      CC_S:      cond_true = flags[FLG_S];
      CC_NS:     cond_true = ~flags[FLG_S];
      CC_V:      cond_true = flags[FLG_V];
      CC_NV:     cond_true = ~flags[FLG_V];
      CC_P:      cond_true = flags[FLG_P];
      CC_NP:     cond_true = ~flags[FLG_P];
      CC_LT:     cond_true = s_xor_v;
      CC_GE:     cond_true = ~s_xor_v;
      default:   cond_true = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_status_stage.sv
// Two-entry result/status buffer behind the 16-bit adder, with condition codes,
// sticky carry/overflow and an accepted-result counter.
module alu_status_stage
  import alu_status_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_sum,
  input  logic             in_carry,
  input  logic             in_sign,
  input  logic             in_zero,
  input  logic             in_parity,
  input  logic             in_overflow,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_sum,
  output logic [4:0]       out_flags,
  input  logic [3:0]       cond_sel,
  output logic             cond_true,
  input  logic             clr_sticky,
  output logic             sticky_c,
  output logic             sticky_v,
  output logic [CNT_W-1:0] acc_count
);

  localparam logic [1:0] FULL = DEPTH[1:0];

  entry_t     mem [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;
  logic       push;
  logic       pop;
  logic       cond_raw;
  entry_t     in_entry;

  assign in_entry = '{sum: in_sum,
                      flags: {in_overflow, in_parity, in_zero, in_sign, in_carry}};

  // Ready depends only on occupancy, so out_ready never reaches in_ready.
  assign in_ready  = (count != FULL);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_sum   = mem[rd_ptr].sum;
  assign out_flags = mem[rd_ptr].flags;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_entry;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop)
        rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // A setting push takes priority over a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_c  <= 1'b0;
      sticky_v  <= 1'b0;
      acc_count <= '0;
    end else begin
      if (push && in_carry)
        sticky_c <= 1'b1;
      else if (clr_sticky)
        sticky_c <= 1'b0;
      if (push && in_overflow)
        sticky_v <= 1'b1;
      else if (clr_sticky)
        sticky_v <= 1'b0;
      if (push)
        acc_count <= acc_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  cond_eval u_cond_eval (
    .cond_sel  (cond_sel),
    .flags     (out_flags),
    .cond_true (cond_raw)
  );

  assign cond_true = out_valid & cond_raw;

endmodule

// File: tb/tb_alu_status_stage.sv
// Directed bench for alu_status_stage: condition-code vector table plus handshake,
// sticky, counter-wrap and async-reset sequences.
module tb_alu_status_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_sum;
  logic        in_carry, in_sign, in_zero, in_parity, in_overflow;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_sum;
  logic [4:0]  out_flags;
  logic [3:0]  cond_sel;
  logic        cond_true;
  logic        clr_sticky;
  logic        sticky_c, sticky_v;
  logic [15:0] acc_count;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_acc = 16'd0;

  always #5 clk = ~clk;

  alu_status_stage #(.DEPTH(2), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_sum(in_sum),
    .in_carry(in_carry), .in_sign(in_sign), .in_zero(in_zero),
    .in_parity(in_parity), .in_overflow(in_overflow),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_flags(out_flags),
    .cond_sel(cond_sel), .cond_true(cond_true),
    .clr_sticky(clr_sticky), .sticky_c(sticky_c), .sticky_v(sticky_v),
    .acc_count(acc_count)
  );

  typedef struct {
    logic [15:0] sum;
    logic [4:0]  flags;   // {v,p,z,s,c}
    logic [3:0]  sel;
    logic        exp_cond;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] s, input logic [4:0] f);
    in_valid    = v;
    in_sum      = s;
    in_carry    = f[0];
    in_sign     = f[1];
    in_zero     = f[2];
    in_parity   = f[3];
    in_overflow = f[4];
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_in_ready"},  in_ready, 1);
    chk({tag, "_out_sum"},   out_sum, 0);
    chk({tag, "_out_flags"}, out_flags, 0);
    chk({tag, "_cond_true"}, cond_true, 0);
    chk({tag, "_sticky_c"},  sticky_c, 0);
    chk({tag, "_sticky_v"},  sticky_v, 0);
    chk({tag, "_acc_count"}, acc_count, 0);
  endtask

  initial begin
    vecs[0]  = '{16'h0000, 5'b00100, 4'd1,  1'b1};
    vecs[1]  = '{16'h0000, 5'b00100, 4'd2,  1'b0};
    vecs[2]  = '{16'h8000, 5'b00010, 4'd11, 1'b1};
    vecs[3]  = '{16'hFFFF, 5'b11111, 4'd13, 1'b0};
    vecs[4]  = '{16'h1234, 5'b00000, 4'd0,  1'b1};
    vecs[5]  = '{16'h0001, 5'b00001, 4'd3,  1'b1};
    vecs[6]  = '{16'h0001, 5'b00001, 4'd4,  1'b0};
    vecs[7]  = '{16'h8001, 5'b10010, 4'd12, 1'b1};
    vecs[8]  = '{16'h0003, 5'b01000, 4'd9,  1'b1};
    vecs[9]  = '{16'h0003, 5'b01000, 4'd10, 1'b0};
    vecs[10] = '{16'h9000, 5'b00010, 4'd5,  1'b1};
    vecs[11] = '{16'h9000, 5'b00010, 4'd6,  1'b0};
    vecs[12] = '{16'h7000, 5'b10000, 4'd7,  1'b1};
    vecs[13] = '{16'h7000, 5'b00000, 4'd8,  1'b1};
    vecs[14] = '{16'h7000, 5'b00000, 4'd15, 1'b0};

    rst_n = 1'b0; out_ready = 1'b0; cond_sel = 4'd0; clr_sticky = 1'b0;
    drive(1'b0, 16'h0, 5'b0);
    #12;
    chk_reset_state("reset");
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // First push: 0xBFFF with carry and overflow
    out_ready = 1'b1;
    drive(1'b1, 16'hBFFF, 5'b10001);
    step(); exp_acc++;
    drive(1'b0, 16'h0, 5'b0);
    chk("p1_out_valid", out_valid, 1);
    chk("p1_out_sum",   out_sum, 16'hBFFF);
    chk("p1_out_flags", out_flags, 5'b10001);
    chk("p1_sticky_c",  sticky_c, 1);
    chk("p1_sticky_v",  sticky_v, 1);
    chk("p1_acc_count", acc_count, 1);
    step();
    chk("p1_drained", out_valid, 0);

    // Back-pressure: three pushes, third refused
    out_ready = 1'b0;
    drive(1'b1, 16'h0001, 5'b0);
    step(); exp_acc++;
    chk("bp_in_ready_1", in_ready, 1);
    drive(1'b1, 16'h0002, 5'b0);
    step(); exp_acc++;
    chk("bp_in_ready_full", in_ready, 0);
    drive(1'b1, 16'h0003, 5'b0);
    step();
    chk("bp_refused_ready", in_ready, 0);
    chk("bp_head_held", out_sum, 16'h0001);
    chk("bp_acc_count", acc_count, exp_acc);
    drive(1'b0, 16'h0, 5'b0);
    out_ready = 1'b1;
    step();
    chk("bp_drain_head2", out_sum, 16'h0002);
    chk("bp_drain_valid2", out_valid, 1);
    step();
    chk("bp_drain_empty", out_valid, 0);

    // Simultaneous push and pop at count=1
    out_ready = 1'b0;
    drive(1'b1, 16'h0011, 5'b0);
    step(); exp_acc++;
    out_ready = 1'b1;
    drive(1'b1, 16'h0022, 5'b0);
    step(); exp_acc++;
    chk("pp_valid", out_valid, 1);
    chk("pp_head", out_sum, 16'h0022);
    chk("pp_in_ready", in_ready, 1);
    drive(1'b0, 16'h0, 5'b0);
    step();
    chk("pp_empty", out_valid, 0);

    // Condition-code table
    for (int i = 0; i < 15; i++) begin
      out_ready = 1'b0;
      cond_sel  = vecs[i].sel;
      drive(1'b1, vecs[i].sum, vecs[i].flags);
      step(); exp_acc++;
      drive(1'b0, 16'h0, 5'b0);
      chk($sformatf("vec%0d_sum", i), out_sum, vecs[i].sum);
      chk($sformatf("vec%0d_flags", i), out_flags, vecs[i].flags);
      chk($sformatf("vec%0d_cond", i), cond_true, vecs[i].exp_cond);
      out_ready = 1'b1;
      step();
    end
    cond_sel = 4'd0;
    #1;
    chk("cond_gated_empty", cond_true, 0);

    // Sticky clear vs set priority
    clr_sticky = 1'b1;
    step();
    chk("stk_clear_c", sticky_c, 0);
    chk("stk_clear_v", sticky_v, 0);
    drive(1'b1, 16'h0005, 5'b00001);
    step(); exp_acc++;
    drive(1'b0, 16'h0, 5'b0);
    chk("stk_set_wins", sticky_c, 1);
    step();
    clr_sticky = 1'b0;
    chk("stk_clear_alone", sticky_c, 0);

    // Accepted-count wrap
    chk("acc_before_wrap", acc_count, exp_acc);
    out_ready = 1'b1;
    drive(1'b1, 16'h0, 5'b0);
    repeat (int'(16'hFFFF - exp_acc)) @(posedge clk);
    #1;
    chk("acc_at_ffff", acc_count, 16'hFFFF);
    step();
    chk("acc_wrapped", acc_count, 16'h0000);
    drive(1'b0, 16'h0, 5'b0);
    step();

    // Asynchronous reset with the buffer full
    out_ready = 1'b0;
    drive(1'b1, 16'hAAAA, 5'b10001);
    step();
    drive(1'b1, 16'h5555, 5'b00010);
    step();
    drive(1'b0, 16'h0, 5'b0);
    chk("full_before_reset", in_ready, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_state("async_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
